// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RISC-V data-memory responder: FSM encoding,
// data widths and the address legality check.
package riscv_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;
  localparam logic [1:0] WORD_ALIGN = 2'b00;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  // Misaligned or beyond the last stored byte.
  function automatic logic addr_err(input logic [XLEN-1:0] addr, input int unsigned depth_words);
    logic [63:0] limit;
    limit = 64'(depth_words) * 64'(BYTES_PER_WORD);
    return (addr[1:0] != WORD_ALIGN) || ({32'h0000_0000, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with per-byte write enables; writes on the rising edge,
// read port is combinational so the caller registers it at its commit point.
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   widx,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   ridx,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_r [DEPTH_WORDS];

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem_r[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_r[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request in flight, programmable wait states,
// commit (write, read sample, error) on the edge that enters RESP.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic BYPASS = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t      state_r;
  logic [3:0]      cnt_r;
  logic            we_r;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] wdata_r;
  logic [BE_W-1:0] be_r;
  logic            req_ready_r;
  logic            rsp_valid_r;
  logic [XLEN-1:0] rsp_rdata_r;
  logic            rsp_err_r;

  logic            accept_s;
  logic            commit_s;
  logic            sel_we_s;
  logic [XLEN-1:0] sel_addr_s;
  logic [XLEN-1:0] sel_wdata_s;
  logic [BE_W-1:0] sel_be_s;
  logic            err_s;
  logic            arr_we_s;
  logic [XLEN-1:0] arr_rdata_s;

  // Commit decode; with no wait states the request commits straight off the ports.
  always_comb begin
    accept_s    = req_valid && req_ready_r && (state_r == ST_IDLE);
    commit_s    = 1'b0;
    sel_we_s    = we_r;
    sel_addr_s  = addr_r;
    sel_wdata_s = wdata_r;
    sel_be_s    = be_r;
    if (BYPASS) begin
      sel_we_s    = req_we;
      sel_addr_s  = req_addr;
      sel_wdata_s = req_wdata;
      sel_be_s    = req_be;
    end else begin
      sel_we_s    = we_r;
      sel_addr_s  = addr_r;
      sel_wdata_s = wdata_r;
      sel_be_s    = be_r;
    end
    case (state_r)
      ST_IDLE: commit_s = accept_s && BYPASS;
      ST_WAIT: commit_s = (cnt_r == 4'd0);
      default: commit_s = 1'b0;
    endcase
    err_s    = addr_err(sel_addr_s, DEPTH_WORDS);
    arr_we_s = commit_s && sel_we_s && !err_s;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we_s),
    .be   (sel_be_s),
    .widx (sel_addr_s[AW+1:2]),
    .wdata(sel_wdata_s),
    .ridx (sel_addr_s[AW+1:2]),
    .rdata(arr_rdata_s)
  );

  // Request FSM, capture registers and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      be_r        <= '0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          req_ready_r <= 1'b1;
          if (accept_s) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            be_r        <= req_be;
            req_ready_r <= 1'b0;
            if (BYPASS) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b0;
        end
      endcase
      if (commit_s) begin
        rsp_err_r   <= err_s;
        rsp_rdata_r <= (err_s || sel_we_s) ? 32'h0000_0000 : arr_rdata_s;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with an expected-response scoreboard.
module tb_dmem_responder;

  localparam int unsigned WAIT_CYCLES = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; stall > 0 holds rsp_ready low for that many cycles.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err,
                     input int stall);
    exp_t e;
    int   n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h0000_0044;
    req_wdata = ~wdata;
    req_be    = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk("latency", 32'(n), 32'(WAIT_CYCLES + 1));
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_rdata", rsp_rdata, e.rdata);
        chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0010;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    rsp_ready = 1'b1;
    #20;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Full, partial and empty stores on one word
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    txn(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);
    txn(1'b1, 32'h10, 32'h5566_7788, 4'b0000, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 0);
    txn(1'b1, 32'h10, 32'h1122_3344, 4'b1010, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 32'h11AD_33AA, 1'b0, 0);

    // Error cases must not disturb memory
    txn(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);
    txn(1'b1, 32'h12, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h11AD_33AA, 1'b0, 0);
    txn(1'b1, 32'hFFC, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0, 0);
    txn(1'b0, 32'hFFC, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);

    // Backpressure
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h11AD_33AA, 1'b0, 5);

    // Reset while a store waits: the store is dropped
    txn(1'b1, 32'h20, 32'h1111_2222, 4'hF, 32'h0, 1'b0, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h1111_2222, 1'b0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
